inst_u_dec: RTL and testbench

Registered decoder for RISC-V U-type instructions (LUI, AUIPC) in the instruction-decode stage. It takes a 32-bit instruction word and extracts the 20-bit upper immediate, the destination register index and the opcode class. It also produces the shifted 32-bit immediate. All outputs are registered one cycle after the fetch stage presents a valid word.

---
 rtl/inst_u_dec.sv | 79 +++++++
 tb/tb_inst_u_dec.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/inst_u_dec.sv
// ============================================================================
// Module   : inst_u_dec
// Purpose  : Registered RV32 U-type (LUI/AUIPC) field and class decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_u_dec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        stall,
    input  logic [31:0] instruction_word,
    output logic        out_valid,
    output logic [19:0] imm_U,
    output logic [4:0]  rd,
    output logic [31:0] imm32,
    output logic        is_lui,
    output logic        is_auipc,
    output logic        u_type,
    output logic        illegal
);

    localparam logic [6:0] c_opc_lui   = 7'b0110111;
    localparam logic [6:0] c_opc_auipc = 7'b0010111;

    logic        out_valid_q, out_valid_d;
    logic [19:0] imm_u_q,     imm_u_d;
    logic [4:0]  rd_q,        rd_d;
    logic        lui_q,       lui_d;
    logic        auipc_q,     auipc_d;

    // Fields are captured for every accepted word; only the flags look at the opcode.
    always_comb begin
        out_valid_d = out_valid_q;
        imm_u_d     = imm_u_q;
        rd_d        = rd_q;
        lui_d       = lui_q;
        auipc_d     = auipc_q;
        if (!stall) begin
            out_valid_d = in_valid;
            if (in_valid) begin
                imm_u_d = instruction_word[31:12];
                rd_d    = instruction_word[11:7];
                lui_d   = (instruction_word[6:0] == c_opc_lui);
                auipc_d = (instruction_word[6:0] == c_opc_auipc);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            imm_u_q     <= 20'h00000;
            rd_q        <= 5'd0;
            lui_q       <= 1'b0;
            auipc_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            imm_u_q     <= imm_u_d;
            rd_q        <= rd_d;
            lui_q       <= lui_d;
            auipc_q     <= auipc_d;
        end
    end

    // Stored flags survive idle cycles, so they are qualified by out_valid here.
    assign out_valid = out_valid_q;
    assign imm_U     = imm_u_q;
    assign rd        = rd_q;
    assign imm32     = {imm_u_q, 12'h000};
    assign is_lui    = out_valid_q & lui_q;
    assign is_auipc  = out_valid_q & auipc_q;
    assign u_type    = is_lui | is_auipc;
    assign illegal   = out_valid_q & ~u_type;

endmodule

`default_nettype wire

// File: tb/tb_inst_u_dec.sv
// ============================================================================
// Module   : tb_inst_u_dec
// Purpose  : Self-checking bench for inst_u_dec (directed plus random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_u_dec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic [31:0] instruction_word;
    logic        out_valid;
    logic [19:0] imm_U;
    logic [4:0]  rd;
    logic [31:0] imm32;
    logic        is_lui;
    logic        is_auipc;
    logic        u_type;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    // Reference state: whether a word is being presented and the last word accepted.
    bit          m_valid;
    logic [31:0] m_word;

    inst_u_dec dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .stall            (stall),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .imm_U            (imm_U),
        .rd               (rd),
        .imm32            (imm32),
        .is_lui           (is_lui),
        .is_auipc         (is_auipc),
        .u_type           (u_type),
        .illegal          (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int unsigned opc;
        int unsigned e_imm;
        int unsigned e_rd;
        bit e_lui;
        bit e_auipc;
        opc     = m_word % 128;
        e_imm   = m_word / 4096;
        e_rd    = (m_word / 128) % 32;
        e_lui   = m_valid && (opc == 55);
        e_auipc = m_valid && (opc == 23);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("imm_U",     {12'd0, imm_U},     e_imm);
        chk("rd",        {27'd0, rd},        e_rd);
        chk("imm32",     imm32,              e_imm * 4096);
        chk("is_lui",    {31'd0, is_lui},    {31'd0, e_lui});
        chk("is_auipc",  {31'd0, is_auipc},  {31'd0, e_auipc});
        chk("u_type",    {31'd0, u_type},    {31'd0, e_lui | e_auipc});
        chk("illegal",   {31'd0, illegal},   {31'd0, m_valid && !(e_lui || e_auipc)});
    endtask

    // Drive one cycle, update the reference at the edge, check just after it.
    task automatic step(input bit v, input bit s, input logic [31:0] w);
        in_valid         = v;
        stall            = s;
        instruction_word = w;
        @(posedge clk);
        if (!s) begin
            m_valid = v;
            if (v) m_word = w;
        end
        #1;
        check_model();
    endtask

    task automatic async_reset();
        #2;
        rst_n   = 1'b0;
        m_valid = 1'b0;
        m_word  = 32'd0;
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h37 ^ (7'd1 << $urandom_range(0, 6));
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        m_valid          = 1'b0;
        m_word           = 32'd0;
        rst_n            = 1'b0;
        in_valid         = 1'b1;
        stall            = 1'b0;
        instruction_word = 32'h0F56B6B7;
        #2;
        instruction_word = 32'hFFFFFFFF;
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 32'h0F56B6B7);

        step(1, 0, 32'h0F56B6B7);
        chk("lui_imm",   {12'd0, imm_U}, 32'h0000F56B);
        chk("lui_rd",    {27'd0, rd},    32'd13);
        chk("lui_imm32", imm32,          32'h0F56B000);
        chk("lui_flag",  {31'd0, is_lui}, 32'd1);

        step(1, 0, 32'h8B549AB7);
        chk("lui_hi_imm32", imm32,       32'h8B549000);
        chk("lui_hi_rd",    {27'd0, rd}, 32'd21);

        step(1, 0, 32'h8B549A97);
        chk("auipc_flag", {31'd0, is_auipc}, 32'd1);
        chk("auipc_lui",  {31'd0, is_lui},   32'd0);

        step(1, 0, 32'h00B50533);
        chk("rtype_illegal", {31'd0, illegal}, 32'd1);
        chk("rtype_rd",      {27'd0, rd},      32'd10);

        step(0, 0, 32'h0F56B6B7);
        chk("idle_illegal", {31'd0, illegal}, 32'd0);
        chk("idle_rd_hold", {27'd0, rd},      32'd10);

        step(1, 0, 32'h0F56B6B7);
        step(1, 1, 32'h8B549AB7);
        step(1, 1, 32'h8B549AB7);
        chk("stall_hold", {12'd0, imm_U}, 32'h0000F56B);
        step(1, 0, 32'h8B549AB7);
        chk("stall_release", {12'd0, imm_U}, 32'h0008B549);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rand_word());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
